mem_bus_arbiter: RTL and testbench

Two-master arbiter sharing the single memory data-bus port (addr / accessType / dataIn / dataOut / ready) between the CPU core (master 0) and a second requester such as a DMA or debug engine (master 1). A grant is held for one complete transaction, and the slave's ready is returned only to the owner. A watchdog aborts transactions that never receive ready. The block sits between the masters and the memory/MMU data-bus slave.

---
 rtl/mem_bus_arbiter.sv | 72 +++++++
 tb/tb_mem_bus_arbiter.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-master arbiter for one memory data-bus slave with a per-transaction grant and a watchdog abort.
module mem_bus_arbiter #(
  parameter int FIXED_PRIO = 0,
  parameter int TIMEOUT = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_accessType,
  input  logic [31:0] m0_dataOut,
  output logic [31:0] m0_dataIn,
  output logic        m0_ready,
  output logic        m0_err,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_accessType,
  input  logic [31:0] m1_dataOut,
  output logic [31:0] m1_dataIn,
  output logic        m1_ready,
  output logic        m1_err,
  output logic [31:0] s_addr,
  output logic [1:0]  s_accessType,
  output logic [31:0] s_dataOut,
  input  logic [31:0] s_dataIn,
  input  logic        s_ready,
  output logic [1:0]  grant
);
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY0 = 2'b01, BUSY1 = 2'b10} state_t;
  localparam logic [TIMEOUT_W-1:0] T_LAST = TIMEOUT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);
  state_t state, state_n;
  logic last_owner, last_owner_n;
  logic [TIMEOUT_W-1:0] count;
  logic r0, r1, b0, b1, req, tmo;
  assign r0 = m0_accessType != 2'b00;
  assign r1 = m1_accessType != 2'b00;
  assign b0 = state == BUSY0;
  assign b1 = state == BUSY1;
  assign req = (b0 && r0) || (b1 && r1);
  // a master that has already dropped its request is aborting, so it never sees err
  assign tmo = TIMEOUT != 0 && req && !s_ready && count == T_LAST;
  assign grant = state;
  assign s_addr = b0 ? m0_addr : b1 ? m1_addr : '0;
  assign s_accessType = b0 ? m0_accessType : b1 ? m1_accessType : 2'b00;
  assign s_dataOut = b0 ? m0_dataOut : b1 ? m1_dataOut : '0;
  assign m0_dataIn = s_dataIn;
  assign m1_dataIn = s_dataIn;
  assign m0_ready = b0 && s_ready;
  assign m1_ready = b1 && s_ready;
  assign m0_err = b0 && tmo;
  assign m1_err = b1 && tmo;
  always_comb begin
    state_n = state;
    last_owner_n = last_owner;
    if (state == IDLE)
      state_n = (r0 && (!r1 || FIXED_PRIO != 0 || last_owner)) ? BUSY0 : r1 ? BUSY1 : IDLE;
    else if (s_ready || !req || tmo) begin
      state_n = IDLE;
      last_owner_n = (s_ready || tmo) ? b1 : last_owner;
    end
  end
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= IDLE;
      last_owner <= 1'b1;
      count <= '0;
    end else begin
      state <= state_n;
      last_owner <= last_owner_n;
      count <= (state == IDLE) ? '0 : (!s_ready && count != '1) ? count + 1'b1 : count;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard-driven bench for mem_bus_arbiter in round-robin and fixed-priority builds.
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;
  logic [31:0] m0_addr, m0_dataOut, m1_addr, m1_dataOut, s_dataIn;
  logic [1:0] m0_accessType, m1_accessType;
  logic s_ready, s_ready_fp;
  logic [31:0] m0_dataIn, m1_dataIn, s_addr, s_dataOut;
  logic [1:0] s_accessType, grant;
  logic m0_ready, m0_err, m1_ready, m1_err;
  logic [31:0] f_m0_dataIn, f_m1_dataIn, f_s_addr, f_s_dataOut;
  logic [1:0] f_s_accessType, f_grant;
  logic f_m0_ready, f_m0_err, f_m1_ready, f_m1_err;
  int total = 0;
  int bad = 0;
  logic [1:0] exp_gnt[$];
  logic [31:0] exp_addr[$];

  mem_bus_arbiter #(.FIXED_PRIO(0), .TIMEOUT(4), .TIMEOUT_W(8)) dut (
    .clk(clk), .res(res),
    .m0_addr(m0_addr), .m0_accessType(m0_accessType), .m0_dataOut(m0_dataOut),
    .m0_dataIn(m0_dataIn), .m0_ready(m0_ready), .m0_err(m0_err),
    .m1_addr(m1_addr), .m1_accessType(m1_accessType), .m1_dataOut(m1_dataOut),
    .m1_dataIn(m1_dataIn), .m1_ready(m1_ready), .m1_err(m1_err),
    .s_addr(s_addr), .s_accessType(s_accessType), .s_dataOut(s_dataOut),
    .s_dataIn(s_dataIn), .s_ready(s_ready), .grant(grant)
  );

  mem_bus_arbiter #(.FIXED_PRIO(1), .TIMEOUT(4), .TIMEOUT_W(8)) dut_fp (
    .clk(clk), .res(res),
    .m0_addr(m0_addr), .m0_accessType(m0_accessType), .m0_dataOut(m0_dataOut),
    .m0_dataIn(f_m0_dataIn), .m0_ready(f_m0_ready), .m0_err(f_m0_err),
    .m1_addr(m1_addr), .m1_accessType(m1_accessType), .m1_dataOut(m1_dataOut),
    .m1_dataIn(f_m1_dataIn), .m1_ready(f_m1_ready), .m1_err(f_m1_err),
    .s_addr(f_s_addr), .s_accessType(f_s_accessType), .s_dataOut(f_s_dataOut),
    .s_dataIn(s_dataIn), .s_ready(s_ready_fp), .grant(f_grant)
  );

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_accessType = 2'd0; m1_accessType = 2'd0;
    m0_addr = '0; m1_addr = '0; m0_dataOut = '0; m1_dataOut = '0;
    s_dataIn = '0; s_ready = 1'b0; s_ready_fp = 1'b0;
    exp_gnt.delete(); exp_addr.delete();
  endtask

  task automatic do_reset();
    res = 1'b1;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 res = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    clear_inputs();
    m0_accessType = 2'd1; m0_addr = 32'h55; m0_dataOut = 32'h66; s_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL reset_grant got=%b want=00", grant); end
    total++; if (s_accessType !== 2'd0) begin bad++; $display("FAIL reset_type got=%0d want=0", s_accessType); end
    total++; if (s_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h want=0", s_addr); end
    total++; if (s_dataOut !== 32'h0) begin bad++; $display("FAIL reset_dout got=%h want=0", s_dataOut); end
    total++; if (m0_ready !== 1'b0) begin bad++; $display("FAIL reset_m0_ready got=%b want=0", m0_ready); end
    do_reset();
  endtask

  task automatic test_basic_read();
    logic [1:0] eg;
    logic [31:0] ea;
    do_reset();
    m0_accessType = 2'd1; m0_addr = 32'h100; s_dataIn = 32'hDEAD_BEEF;
    exp_gnt.push_back(2'b01); exp_addr.push_back(32'h100);
    for (int c = 0; c < 5; c++) begin
      s_ready = (c == 3);
      if (c == 4) m0_accessType = 2'd0;
      @(negedge clk);
      if (c == 0 || c == 4) begin
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL basic_idle_grant c=%0d got=%b want=00", c, grant); end
        total++; if (s_accessType !== 2'd0) begin bad++; $display("FAIL basic_idle_type c=%0d got=%0d want=0", c, s_accessType); end
      end
      if (c == 1) begin
        eg = exp_gnt.pop_front(); ea = exp_addr.pop_front();
        total++; if (grant !== eg) begin bad++; $display("FAIL basic_grant got=%b want=%b", grant, eg); end
        total++; if (s_addr !== ea) begin bad++; $display("FAIL basic_addr got=%h want=%h", s_addr, ea); end
      end
      if (c >= 1 && c <= 3) begin
        total++; if (s_accessType !== 2'd1 || s_addr !== 32'h100) begin bad++; $display("FAIL basic_slave c=%0d got=%0d/%h want=1/100", c, s_accessType, s_addr); end
      end
      total++; if (m0_ready !== (c == 3)) begin bad++; $display("FAIL basic_m0_ready c=%0d got=%b want=%b", c, m0_ready, c == 3); end
      total++; if (m1_ready !== 1'b0) begin bad++; $display("FAIL basic_m1_ready c=%0d got=%b want=0", c, m1_ready); end
      if (c == 3) begin
        total++; if (m0_dataIn !== 32'hDEAD_BEEF || m1_dataIn !== 32'hDEAD_BEEF) begin bad++; $display("FAIL basic_rdata got=%h/%h want=deadbeef", m0_dataIn, m1_dataIn); end
      end
      go();
    end
  endtask

  task automatic test_arbitration(input bit fp);
    int busy, cyc;
    bit gap, srv;
    logic [1:0] g, eg;
    logic [31:0] sa, ea;
    logic r0v, r1v;
    do_reset();
    m0_accessType = 2'd1; m0_addr = 32'hA0; m1_accessType = 2'd2; m1_addr = 32'hB0;
    for (int i = 0; i < 4; i++) begin
      exp_gnt.push_back((fp || i % 2 == 0) ? 2'b01 : 2'b10);
      exp_addr.push_back((fp || i % 2 == 0) ? 32'hA0 : 32'hB0);
    end
    busy = 0; cyc = 0; gap = 1'b0;
    while (exp_gnt.size() > 0 && cyc < 60) begin
      g = fp ? f_grant : grant;
      srv = (g != 2'b00) && busy == 1;
      if (fp) s_ready_fp = srv; else s_ready = srv;
      @(negedge clk);
      g = fp ? f_grant : grant;
      sa = fp ? f_s_addr : s_addr;
      r0v = fp ? f_m0_ready : m0_ready;
      r1v = fp ? f_m1_ready : m1_ready;
      if (gap) begin
        total++; if (g !== 2'b00) begin bad++; $display("FAIL arb_gap fp=%0d got=%b want=00", fp, g); end
        gap = 1'b0;
      end
      if (fp) begin
        total++; if (r1v !== 1'b0) begin bad++; $display("FAIL arb_fp_m1_ready got=%b want=0", r1v); end
      end
      if (g != 2'b00) begin
        if (busy == 0) begin
          eg = exp_gnt.pop_front(); ea = exp_addr.pop_front();
          total++; if (g !== eg || sa !== ea) begin bad++; $display("FAIL arb_grant fp=%0d got=%b/%h want=%b/%h", fp, g, sa, eg, ea); end
        end
        total++; if ((g == 2'b01 ? r0v : r1v) !== srv || (g == 2'b01 ? r1v : r0v) !== 1'b0) begin bad++; $display("FAIL arb_ready fp=%0d got=%b%b want owner=%b", fp, r1v, r0v, srv); end
        busy++;
        if (srv) begin busy = 0; gap = 1'b1; end
      end
      cyc++;
      go();
    end
    total++; if (exp_gnt.size() != 0) begin bad++; $display("FAIL arb_budget fp=%0d got=%0d pending want=0", fp, exp_gnt.size()); end
    s_ready = 1'b0; s_ready_fp = 1'b0;
  endtask

  task automatic test_timeout();
    logic [1:0] eg;
    logic [31:0] ea;
    do_reset();
    m1_accessType = 2'd2; m1_addr = 32'h200; m1_dataOut = 32'h1234_5678;
    exp_gnt.push_back(2'b10); exp_addr.push_back(32'h200);
    for (int c = 0; c < 7; c++) begin
      if (c == 5) m1_accessType = 2'd0;
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        total++; if (grant !== 2'b10) begin bad++; $display("FAIL to_grant c=%0d got=%b want=10", c, grant); end
      end
      if (c == 1) begin
        eg = exp_gnt.pop_front(); ea = exp_addr.pop_front();
        total++; if (grant !== eg || s_addr !== ea) begin bad++; $display("FAIL to_first got=%b/%h want=%b/%h", grant, s_addr, eg, ea); end
        total++; if (s_dataOut !== 32'h1234_5678 || s_accessType !== 2'd2) begin bad++; $display("FAIL to_wdata got=%h/%0d want=12345678/2", s_dataOut, s_accessType); end
      end
      total++; if (m1_err !== (c == 4)) begin bad++; $display("FAIL to_m1_err c=%0d got=%b want=%b", c, m1_err, c == 4); end
      total++; if (m1_ready !== 1'b0 || m0_err !== 1'b0) begin bad++; $display("FAIL to_other c=%0d got=%b/%b want=0/0", c, m1_ready, m0_err); end
      if (c == 5) begin
        total++; if (s_accessType !== 2'd0 || grant !== 2'b00) begin bad++; $display("FAIL to_idle got=%0d/%b want=0/00", s_accessType, grant); end
      end
      go();
    end
  endtask

  task automatic test_ready_timeout_tie();
    do_reset();
    m0_accessType = 2'd1; m0_addr = 32'h300;
    for (int c = 0; c < 6; c++) begin
      s_ready = (c == 4);
      if (c == 5) m0_accessType = 2'd0;
      @(negedge clk);
      if (c >= 1 && c <= 4) begin
        total++; if (m0_ready !== (c == 4)) begin bad++; $display("FAIL tie_ready c=%0d got=%b want=%b", c, m0_ready, c == 4); end
        total++; if (m0_err !== 1'b0) begin bad++; $display("FAIL tie_err c=%0d got=%b want=0", c, m0_err); end
      end
      if (c == 5) begin
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL tie_idle got=%b want=00", grant); end
      end
      go();
    end
  endtask

  task automatic test_abort();
    logic [1:0] eg;
    logic [31:0] ea;
    do_reset();
    m0_accessType = 2'd1; m0_addr = 32'h400;
    exp_gnt.push_back(2'b01); exp_addr.push_back(32'h400);
    exp_gnt.push_back(2'b01); exp_addr.push_back(32'h400);
    for (int c = 0; c < 5; c++) begin
      if (c == 2) m0_accessType = 2'd0;
      if (c == 3) begin m0_accessType = 2'd1; m1_accessType = 2'd1; m1_addr = 32'h500; end
      @(negedge clk);
      if (c == 1 || c == 4) begin
        eg = exp_gnt.pop_front(); ea = exp_addr.pop_front();
        total++; if (grant !== eg || s_addr !== ea) begin bad++; $display("FAIL abort_grant c=%0d got=%b/%h want=%b/%h", c, grant, s_addr, eg, ea); end
      end
      if (c == 2) begin
        total++; if (m0_ready !== 1'b0 || m0_err !== 1'b0) begin bad++; $display("FAIL abort_pulse got=%b/%b want=0/0", m0_ready, m0_err); end
      end
      if (c == 3) begin
        total++; if (grant !== 2'b00) begin bad++; $display("FAIL abort_idle got=%b want=00", grant); end
      end
      go();
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] eg;
    logic [31:0] ea;
    do_reset();
    m0_accessType = 2'd1; m0_addr = 32'h600;
    go();
    @(negedge clk);
    total++; if (grant !== 2'b01) begin bad++; $display("FAIL mid_busy got=%b want=01", grant); end
    go();
    res = 1'b1; s_ready = 1'b1; m1_accessType = 2'd1; m1_addr = 32'h700;
    #1;
    total++; if (s_accessType !== 2'd0 || grant !== 2'b00) begin bad++; $display("FAIL mid_drop got=%0d/%b want=0/00", s_accessType, grant); end
    total++; if (m0_ready !== 1'b0 || m0_err !== 1'b0) begin bad++; $display("FAIL mid_pulse got=%b/%b want=0/0", m0_ready, m0_err); end
    m0_accessType = 2'd0; s_ready = 1'b0;
    go();
    res = 1'b0;
    exp_gnt.push_back(2'b10); exp_addr.push_back(32'h700);
    @(negedge clk);
    total++; if (grant !== 2'b00) begin bad++; $display("FAIL mid_release got=%b want=00", grant); end
    go();
    @(negedge clk);
    eg = exp_gnt.pop_front(); ea = exp_addr.pop_front();
    total++; if (grant !== eg || s_addr !== ea) begin bad++; $display("FAIL mid_regrant got=%b/%h want=%b/%h", grant, s_addr, eg, ea); end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_arbitration(1'b0);
    test_arbitration(1'b1);
    test_timeout();
    test_ready_timeout_tie();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_time_limit got=expired want=done");
    $fatal(1, "time limit");
  end
endmodule
